// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundle of the digit-load handshake and the display
// outputs of seg7_scan_driver. The master (board logic / bench) drives the
// digit data and the load strobe, the slave (the driver) returns the
// acknowledge, the scan outputs and the frame marker.
//
// Handshake: `load` is a one-cycle strobe. The value and dp_in presented in
// the same cycle are captured. There is no ready; a load is always accepted.
// A newer load before the acknowledge replaces the older one. `load_ack`
// pulses for exactly one cycle when the captured data becomes the displayed
// data. That happens at the end of a scan frame, so a frame never shows a
// mix of old and new digits.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                load_ack;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame_done;

  modport master (
    output value,
    output dp_in,
    output load,
    input  load_ack,
    input  an,
    input  seg,
    input  dp,
    input  frame_done
  );

  modport slave (
    input  value,
    input  dp_in,
    input  load,
    output load_ack,
    output an,
    output seg,
    output dp,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment driver.
// Each digit is lit for REFRESH_DIV clocks, and a frame takes DIGITS*REFRESH_DIV
// clocks. New digit data goes into holding registers. It is committed to the
// display registers only on the last cycle of a frame (the wrap cycle).
// The hex decode gives active-low segments {a,b,c,d,e,f,g}.
// The scan outputs are registered. They show the digit index and display
// registers of the previous cycle.
// Optional feature macro: SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic               clk,
  input logic               reset_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW    = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // scan position
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             term;
  logic             wrap;

  // holding and display registers
  logic [VW-1:0]     hold_v;
  logic [DIGITS-1:0] hold_dp;
  logic              pending;
  logic [VW-1:0]     shadow_v;
  logic [DIGITS-1:0] shadow_dp;

  // selected digit and blanking
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic [DIGITS-1:0] blank;

  // next values of the registered outputs
  logic [DIGITS-1:0] an_c;
  logic [6:0]        seg_c;
  logic              dp_c;

  // output registers
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic              load_ack_q;
  logic              frame_done_q;

  // Hex digit to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // The terminal count ends a digit slot. On the last digit it also ends the frame.
  assign term = (cnt == CNT_LAST);
  assign wrap = term && (idx == IDX_LAST);

  // Refresh prescaler: counts 0..REFRESH_DIV-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit index: advances on each terminal count, wraps after the last digit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (term) begin
      if (idx == IDX_LAST) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Load capture and frame-synchronous commit. A load in the wrap cycle
  // skips the holding stage. It goes directly to the display registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_v     <= '0;
      hold_dp    <= '0;
      pending    <= 1'b0;
      shadow_v   <= '0;
      shadow_dp  <= '0;
      load_ack_q <= 1'b0;
    end else begin
      load_ack_q <= 1'b0;
      if (wrap) begin
        if (bus.load) begin
          shadow_v   <= bus.value;
          shadow_dp  <= bus.dp_in;
          pending    <= 1'b0;
          load_ack_q <= 1'b1;
        end else if (pending) begin
          shadow_v   <= hold_v;
          shadow_dp  <= hold_dp;
          pending    <= 1'b0;
          load_ack_q <= 1'b1;
        end
      end else if (bus.load) begin
        hold_v  <= bus.value;
        hold_dp <= bus.dp_in;
        pending <= 1'b1;
      end
    end
  end

  // End-of-frame marker, one cycle after the wrap cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
    end
  end

`ifdef SEG7_LZB_EN
  logic zero_run;

  // Leading-zero blanking: digit k>0 is dark when it and every digit above are 0.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (shadow_v[4*k +: 4] == 4'd0);
      if (k > 0) begin
        blank[k] = zero_run;
      end
    end
  end
`else
  assign blank = '0;
`endif

  // Select the nibble, dp request and blank flag of the digit now scanned.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = shadow_v[4*k +: 4];
        cur_dp    = shadow_dp[k];
        cur_blank = blank[k];
      end
    end
  end

  // Build the next scan outputs. A blanked digit keeps its anode enabled
  // only when its decimal point is lit.
  always_comb begin
    an_c = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        an_c[k] = cur_blank & ~cur_dp;
      end
    end
    seg_c = cur_blank ? 7'b1111111 : seg7_decode(cur_nib);
    dp_c  = ~cur_dp;
  end

  // Output registers: an, seg and dp change on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an_q  <= '1;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_c;
      seg_q <= seg_c;
      dp_q  <= dp_c;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed and random load and reset stimulus for
// seg7_scan_driver (DIGITS=4, REFRESH_DIV=4). A reference model counts
// cycles since reset. It derives the scan position from that count by
// division and modulo. It predicts every output word into exp_q, and the
// checker compares each prediction on the falling edge.
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int RD    = 4;
  localparam int FRAME = D * RD;
  localparam int VW    = 4 * D;
  localparam int EW    = D + 10;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(D)) bus ();

  seg7_scan_driver #(
    .DIGITS      (D),
    .REFRESH_DIV (RD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) begin
        $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
    end
  endtask

  // reference model: expected {an, seg, dp, frame_done, load_ack}
  logic [EW-1:0] exp_q[$];
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int            m_c;
  logic [VW-1:0] m_hold_v, m_sh_v, m_shift;
  logic [D-1:0]  m_hold_dp, m_sh_dp, m_an;
  logic          m_pend, m_blank, m_wrap, m_ack, m_dp_lit;
  int            m_i;

  // Model step: cycle m_c since reset shows digit (m_c/RD)%D.
  // The last cycle of every FRAME commits.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_c       = 0;
      m_hold_v  = '0;
      m_hold_dp = '0;
      m_pend    = 1'b0;
      m_sh_v    = '0;
      m_sh_dp   = '0;
      exp_q.push_back({{D{1'b1}}, 7'b1111111, 1'b1, 1'b0, 1'b0});
    end else begin
      m_i      = (m_c / RD) % D;
      m_shift  = m_sh_v >> (4 * m_i);
      m_dp_lit = m_sh_dp[m_i];
      m_blank  = 1'b0;
`ifdef SEG7_LZB_EN
      m_blank  = (m_i > 0) && (m_shift == '0);
`endif
      m_an = '1;
      if (!m_blank || m_dp_lit) m_an[m_i] = 1'b0;
      m_wrap = (m_c % FRAME) == (FRAME - 1);
      m_ack  = m_wrap && (m_pend || bus.load);
      exp_q.push_back({m_an, (m_blank ? 7'b1111111 : seg_tab[m_shift[3:0]]),
                       ~m_dp_lit, m_wrap, m_ack});
      if (m_wrap) begin
        if (bus.load) begin
          m_sh_v  = bus.value;
          m_sh_dp = bus.dp_in;
        end else if (m_pend) begin
          m_sh_v  = m_hold_v;
          m_sh_dp = m_hold_dp;
        end
        m_pend = 1'b0;
      end else if (bus.load) begin
        m_hold_v  = bus.value;
        m_hold_dp = bus.dp_in;
        m_pend    = 1'b1;
      end
      m_c++;
    end
  end

  // scoreboard: compare each predicted word away from the active edge
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an",         32'(bus.an),         32'(e[EW-1 -: D]));
      check("seg",        32'(bus.seg),        32'(e[9:3]));
      check("dp",         32'(bus.dp),         32'(e[2]));
      check("frame_done", 32'(bus.frame_done), 32'(e[1]));
      check("load_ack",   32'(bus.load_ack),   32'(e[0]));
    end
  end

  // driver tasks (called just after a falling edge)
  task automatic idle(input int n);
    bus.load = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [VW-1:0] v, input logic [D-1:0] d);
    bus.value = v;
    bus.dp_in = d;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Wait until the next cycle to be clocked is at phase p within the frame.
  task automatic wait_phase(input int p);
    for (int n = 0; n < 2 * FRAME; n++) begin
      if ((m_c % FRAME) == p) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL phase_timeout got=%0d expected=%0d", m_c % FRAME, p);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    // basic scan and decode
    wait_phase(5);
    pulse_load(16'h1234, 4'b0000);
    idle(2 * FRAME);
    wait_phase(3);
    pulse_load(16'hABCD, 4'b0101);
    idle(2 * FRAME);

    // mid-frame load, then two loads in one frame (last wins)
    wait_phase(2);
    pulse_load(16'h5678, 4'b0010);
    idle(FRAME + 4);
    wait_phase(1);
    pulse_load(16'h1111, 4'b1111);
    idle(3);
    pulse_load(16'h2468, 4'b1000);
    idle(2 * FRAME);

    // load exactly in the wrap cycle
    wait_phase(FRAME - 1);
    pulse_load(16'h4321, 4'b0001);
    idle(FRAME + 2);

    // leading zeros, with and without dp on a blankable digit
    wait_phase(6);
    pulse_load(16'h0070, 4'b0000);
    idle(2 * FRAME);
    wait_phase(6);
    pulse_load(16'h0070, 4'b1000);
    idle(2 * FRAME);
    wait_phase(6);
    pulse_load(16'h0000, 4'b0000);
    idle(2 * FRAME);

    // reset while digit 2 is lit and a load is pending
    wait_phase(2);
    pulse_load(16'h9999, 4'b1111);
    wait_phase(2 * RD + 1);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(2 * FRAME);

    // random loads and occasional resets
    for (int n = 0; n < 2000; n++) begin
      bus.load  = ($urandom_range(0, 9) == 0);
      bus.value = VW'($urandom);
      bus.dp_in = D'($urandom);
      reset_n   = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    idle(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
